// File: rtl/acc_finish_arbiter.sv
// acc_finish_arbiter: packet-atomic round-robin merge of accelerator
// finish streams into one TID-tagged stream behind an output register.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   acc_T*             per-accelerator AXI-Stream inputs (64-bit slices)
//   outStream_T*       merged stream, TID = source accelerator index
//   busy               grant held or output register full
//   pkt_count          packets whose TLAST beat left on outStream
module acc_finish_arbiter #(
  parameter int MAX_ACCS = 16,
  parameter int ACC_BITS = $clog2(MAX_ACCS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [64*MAX_ACCS-1:0]   acc_TDATA,
  input  logic [MAX_ACCS-1:0]      acc_TVALID,
  input  logic [MAX_ACCS-1:0]      acc_TLAST,
  output logic [MAX_ACCS-1:0]      acc_TREADY,
  output logic [63:0]              outStream_TDATA,
  output logic                     outStream_TVALID,
  input  logic                     outStream_TREADY,
  output logic [ACC_BITS-1:0]      outStream_TID,
  output logic                     outStream_TLAST,
  output logic                     busy,
  output logic [31:0]              pkt_count
);

  typedef enum logic {
    IDLE,
    FWD
  } state_t;

  state_t              state;
  logic [ACC_BITS-1:0] grant;
  logic [ACC_BITS-1:0] rr_ptr;
  logic [ACC_BITS-1:0] sel;
  logic                found;

  logic [63:0]         out_data;
  logic [ACC_BITS-1:0] out_tid;
  logic                out_last;
  logic                out_valid;
  logic [31:0]         pkt_q;

  logic                slot_free;
  logic                in_hs;
  logic                out_hs;
  logic [63:0]         in_data;
  logic                in_last;

  // Rotating priority: first requester after the last one served.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_ACCS; k++) begin
      if (!found && acc_TVALID[(int'(rr_ptr) + k) % MAX_ACCS]) begin
        sel   = ACC_BITS'((int'(rr_ptr) + k) % MAX_ACCS);
        found = 1'b1;
      end
    end
  end

  // Register accepts a new beat when empty or draining this cycle.
  assign slot_free = !out_valid || outStream_TREADY;
  assign out_hs    = out_valid && outStream_TREADY;
  assign in_data   = acc_TDATA[64*int'(grant) +: 64];
  assign in_last   = acc_TLAST[grant];
  assign in_hs     = (state == FWD) && acc_TVALID[grant] && slot_free;

  always_comb begin
    acc_TREADY = '0;
    if (state == FWD) begin
      acc_TREADY[grant] = slot_free;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= ACC_BITS'(MAX_ACCS - 1);
      grant     <= '0;
      out_data  <= '0;
      out_tid   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      pkt_q     <= '0;
    end else begin
      if (out_hs && out_last) begin
        pkt_q <= pkt_q + 32'd1;
      end
      unique case (state)
        IDLE: begin
          if (out_hs) begin
            out_valid <= 1'b0;
          end
          if (found) begin
            grant  <= sel;
            rr_ptr <= sel;
            state  <= FWD;
          end
        end
        FWD: begin
          if (in_hs) begin
            out_data  <= in_data;
            out_last  <= in_last;
            out_tid   <= grant;
            out_valid <= 1'b1;
            if (in_last) begin
              state <= IDLE;
            end
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign outStream_TDATA  = out_data;
  assign outStream_TVALID = out_valid;
  assign outStream_TID    = out_tid;
  assign outStream_TLAST  = out_last;
  assign busy             = (state == FWD) || out_valid;
  assign pkt_count        = pkt_q;

endmodule

// File: tb/tb_acc_finish_arbiter.sv
// tb_acc_finish_arbiter: directed bench for acc_finish_arbiter.
// Per-accelerator packet sources, output log, hand-computed expectations.
module tb_acc_finish_arbiter;

  localparam int N = 16;

  logic             clk;
  logic             rstn;
  logic [64*N-1:0]  acc_TDATA;
  logic [N-1:0]     acc_TVALID;
  logic [N-1:0]     acc_TLAST;
  logic [N-1:0]     acc_TREADY;
  logic [63:0]      outStream_TDATA;
  logic             outStream_TVALID;
  logic             outStream_TREADY;
  logic [3:0]       outStream_TID;
  logic             outStream_TLAST;
  logic             busy;
  logic [31:0]      pkt_count;

  acc_finish_arbiter #(.MAX_ACCS(N)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .acc_TDATA        (acc_TDATA),
    .acc_TVALID       (acc_TVALID),
    .acc_TLAST        (acc_TLAST),
    .acc_TREADY       (acc_TREADY),
    .outStream_TDATA  (outStream_TDATA),
    .outStream_TVALID (outStream_TVALID),
    .outStream_TREADY (outStream_TREADY),
    .outStream_TID    (outStream_TID),
    .outStream_TLAST  (outStream_TLAST),
    .busy             (busy),
    .pkt_count        (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int nlast = 0;
  bit bp_mode = 1'b0;

  int left [N];
  int plen [N];
  int bidx [N];
  int pno  [N];

  logic [63:0] lg_data [$];
  logic [3:0]  lg_tid  [$];
  logic        lg_last [$];
  int          lg_cyc  [$];

  logic [63:0] bp_exp [3];
  logic [3:0]  rr_tid [4];
  logic [63:0] rr_dat [4];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      plen[i] = 1;
      bidx[i] = 0;
      pno[i]  = 0;
    end
    lg_data.delete();
    lg_tid.delete();
    lg_last.delete();
    lg_cyc.delete();
    nlast = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      acc_TVALID[i] = (left[i] != 0);
      acc_TDATA[64*i +: 64] = (64'(i) << 56) | (64'(pno[i]) << 48)
                            | (64'h11 * 64'(bidx[i] + 1));
      acc_TLAST[i] = (bidx[i] == plen[i] - 1);
    end
  endtask

  task automatic tick(input logic ordy);
    logic [N-1:0] hs;
    outStream_TREADY = ordy;
    drive();
    #1;
    hs = acc_TVALID & acc_TREADY;
    if (bp_mode && outStream_TVALID) begin
      check("bp_count", 64'(lg_data.size() < 3), 64'd1);
      if (lg_data.size() < 3) begin
        check("bp_data", outStream_TDATA, bp_exp[lg_data.size()]);
        check("bp_tid", 64'(outStream_TID), 64'd2);
      end
      if (!ordy) check("bp_rdy", 64'(acc_TREADY[2]), 64'd0);
    end
    if (outStream_TVALID && ordy) begin
      lg_data.push_back(outStream_TDATA);
      lg_tid.push_back(outStream_TID);
      lg_last.push_back(outStream_TLAST);
      lg_cyc.push_back(cyc);
      if (outStream_TLAST) nlast++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        bidx[i]++;
        if (bidx[i] == plen[i]) begin
          bidx[i] = 0;
          pno[i]++;
          left[i]--;
        end
      end
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (nlast < n && k < budget) begin
      tick(1'b1);
      k++;
    end
    check("timeout", 64'(nlast >= n), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear();
    drive();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstn = 1'b0;
    outStream_TREADY = 1'b1;
    acc_TDATA = '0;
    acc_TVALID = '0;
    acc_TLAST = '0;
    clear();
    bp_exp = '{64'h0200_0000_0000_0011, 64'h0200_0000_0000_0022,
               64'h0200_0000_0000_0033};
    rr_tid = '{4'd0, 4'd3, 4'd7, 4'd0};
    rr_dat = '{64'h0000_0000_0000_0011, 64'h0300_0000_0000_0011,
               64'h0700_0000_0000_0011, 64'h0001_0000_0000_0011};

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(outStream_TVALID), 64'd0);
    check("rst_data", outStream_TDATA, 64'd0);
    check("rst_tid", 64'(outStream_TID), 64'd0);
    check("rst_last", 64'(outStream_TLAST), 64'd0);
    check("rst_ready", 64'(acc_TREADY), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(pkt_count), 64'd0);
    rstn = 1'b1;

    // single requester
    clear();
    left[5] = 1;
    plen[5] = 3;
    run_until(1, 40);
    check("t1_len", 64'(lg_data.size()), 64'd3);
    if (lg_data.size() == 3) begin
      check("t1_d0", lg_data[0], 64'h0500_0000_0000_0011);
      check("t1_d1", lg_data[1], 64'h0500_0000_0000_0022);
      check("t1_d2", lg_data[2], 64'h0500_0000_0000_0033);
      check("t1_tid0", 64'(lg_tid[0]), 64'd5);
      check("t1_tid2", 64'(lg_tid[2]), 64'd5);
      check("t1_l0", 64'(lg_last[0]), 64'd0);
      check("t1_l1", 64'(lg_last[1]), 64'd0);
      check("t1_l2", 64'(lg_last[2]), 64'd1);
      check("t1_gap", 64'(lg_cyc[2] - lg_cyc[0]), 64'd2);
    end
    check("t1_cnt", 64'(pkt_count), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);

    // round robin
    do_reset();
    left[0] = 2;
    plen[0] = 3;
    left[3] = 1;
    plen[3] = 3;
    left[7] = 1;
    plen[7] = 3;
    run_until(4, 80);
    check("rr_len", 64'(lg_data.size()), 64'd12);
    if (lg_data.size() == 12) begin
      for (int p = 0; p < 4; p++) begin
        check("rr_tid_a", 64'(lg_tid[3*p]), 64'(rr_tid[p]));
        check("rr_tid_b", 64'(lg_tid[3*p+1]), 64'(rr_tid[p]));
        check("rr_tid_c", 64'(lg_tid[3*p+2]), 64'(rr_tid[p]));
        check("rr_data", lg_data[3*p], rr_dat[p]);
        check("rr_last_a", 64'(lg_last[3*p]), 64'd0);
        check("rr_last_c", 64'(lg_last[3*p+2]), 64'd1);
        check("rr_burst", 64'(lg_cyc[3*p+2] - lg_cyc[3*p]), 64'd2);
        if (p > 0) check("rr_idle", 64'(lg_cyc[3*p] - lg_cyc[3*p-1]), 64'd2);
      end
    end
    check("rr_cnt", 64'(pkt_count), 64'd4);

    // backpressure
    do_reset();
    left[2] = 1;
    plen[2] = 3;
    bp_mode = 1'b1;
    k = 0;
    while (nlast < 1 && k < 60) begin
      tick((k % 4 == 0) || (k % 4 == 3));
      k++;
    end
    bp_mode = 1'b0;
    check("bp_timeout", 64'(nlast >= 1), 64'd1);
    check("bp_len", 64'(lg_data.size()), 64'd3);
    check("bp_cnt", 64'(pkt_count), 64'd1);

    // grant lock
    do_reset();
    left[9] = 1;
    plen[9] = 3;
    k = 0;
    while (bidx[9] != 2 && k < 40) begin
      tick(1'b1);
      k++;
    end
    check("gl_reach", 64'(bidx[9]), 64'd2);
    left[1] = 1;
    plen[1] = 1;
    drive();
    #1;
    check("gl_rdy1", 64'(acc_TREADY[1]), 64'd0);
    check("gl_rdy9", 64'(acc_TREADY[9]), 64'd1);
    run_until(2, 40);
    check("gl_len", 64'(lg_data.size()), 64'd4);
    if (lg_data.size() == 4) begin
      check("gl_tid2", 64'(lg_tid[2]), 64'd9);
      check("gl_d2", lg_data[2], 64'h0900_0000_0000_0033);
      check("gl_tid3", 64'(lg_tid[3]), 64'd1);
      check("gl_d3", lg_data[3], 64'h0100_0000_0000_0011);
      check("gl_l3", 64'(lg_last[3]), 64'd1);
    end
    check("gl_cnt", 64'(pkt_count), 64'd2);

    // async reset mid-packet
    clear();
    left[4] = 1;
    plen[4] = 3;
    k = 0;
    while (bidx[4] != 1 && k < 40) begin
      tick(1'b1);
      k++;
    end
    check("ar_reach", 64'(bidx[4]), 64'd1);
    drive();
    #2;
    check("ar_pre_valid", 64'(outStream_TVALID), 64'd1);
    rstn = 1'b0;
    #1;
    check("ar_valid", 64'(outStream_TVALID), 64'd0);
    check("ar_ready", 64'(acc_TREADY), 64'd0);
    check("ar_cnt", 64'(pkt_count), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    clear();
    left[0] = 1;
    left[6] = 1;
    drive();
    @(negedge clk);
    rstn = 1'b1;
    run_until(2, 40);
    check("ar_len", 64'(lg_data.size()), 64'd2);
    if (lg_data.size() == 2) begin
      check("ar_tid0", 64'(lg_tid[0]), 64'd0);
      check("ar_tid1", 64'(lg_tid[1]), 64'd6);
      check("ar_d1", lg_data[1], 64'h0600_0000_0000_0011);
    end

    // counter wrap
    clear();
    @(negedge clk);
    force dut.pkt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_q;
    check("wr_pre", 64'(pkt_count), 64'h0000_0000_FFFF_FFFF);
    left[15] = 1;
    run_until(1, 40);
    check("wr_cnt", 64'(pkt_count), 64'd0);
    check("wr_len", 64'(lg_data.size()), 64'd1);
    if (lg_data.size() == 1) begin
      check("wr_tid", 64'(lg_tid[0]), 64'd15);
      check("wr_last", 64'(lg_last[0]), 64'd1);
      check("wr_data", lg_data[0], 64'h0F00_0000_0000_0011);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/acc_finish_arbiter.md
Name: acc_finish_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges per-accelerator finish-message streams into the single TID-tagged stream consumed by the command-out stage.
- Each accelerator emits a finish packet of header, task id and parent task id. The last beat is marked TLAST.
- The block grants one accelerator at a time and holds the grant until the TLAST beat is accepted. It forwards beats through one output register stage and tags them with the source index.

Parameters:
- MAX_ACCS, 16, number of accelerator input streams (≥2).
- ACC_BITS, $clog2(MAX_ACCS), width of TID and grant index.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- acc_TDATA  in  64*MAX_ACCS  per-accelerator data; slice i = [64*i+63:64*i].
- acc_TVALID  in  MAX_ACCS  per-accelerator valid.
- acc_TLAST  in  MAX_ACCS  per-accelerator last-beat flag.
- acc_TREADY  out  MAX_ACCS  per-accelerator ready.
- outStream_TDATA  out  64  merged data.
- outStream_TVALID  out  1  merged valid.
- outStream_TREADY  in  1  downstream ready.
- outStream_TID  out  ACC_BITS  source accelerator index.
- outStream_TLAST  out  1  last beat of packet.
- busy  out  1  high while a grant is held or the output register is full.
- pkt_count  out  32  number of packets whose TLAST beat left on outStream; wraps at 2^32.

Behaviour:
- Reset (rstn=0, async) forces:
  - state=IDLE, rr_ptr=MAX_ACCS-1;
  - outStream_TVALID=0, outStream_TDATA=0, outStream_TID=0, outStream_TLAST=0;
  - acc_TREADY=0, busy=0, pkt_count=0.
- Deassertion takes effect on the next clk edge.
- Reset mid-packet discards the partial packet. Upstream sees TREADY drop and must not assume completion.
- State machine has two states, IDLE and FWD.
- IDLE:
  - acc_TREADY=0.
  - If any acc_TVALID is set, select the first set bit searching rr_ptr+1, rr_ptr+2, … modulo MAX_ACCS.
  - On selection: grant<=selected, rr_ptr<=selected, go to FWD.
  - If no acc_TVALID is set, stay in IDLE.
- FWD:
  - acc_TREADY[grant] = !outStream_TVALID | outStream_TREADY. All other TREADY bits are 0.
  - On an input handshake (acc_TVALID[grant] & acc_TREADY[grant]), on the same edge: outStream_TDATA<=slice, outStream_TLAST<=acc_TLAST[grant], outStream_TID<=grant, outStream_TVALID<=1.
  - If the accepted beat has TLAST=1, go to IDLE.
  - If the output handshakes with no new input beat, outStream_TVALID<=0.
- Latency: a beat accepted at edge N is visible on outStream in cycle N+1.
- Throughput: one beat/cycle within a packet while outStream_TREADY=1.
- Exactly one IDLE arbitration cycle occurs between packets.
- Output hold rule: while outStream_TVALID=1 & outStream_TREADY=0, TDATA, TID and TLAST hold stable. The granted TREADY is 0 during this time.
- A grant never changes mid-packet, even if higher-priority requesters assert valid. TVALID deasserting mid-packet just stalls FWD.
- pkt_count increments by 1 on each outStream handshake with TLAST=1. It wraps 0xFFFFFFFF→0.
- busy = (state==FWD) | outStream_TVALID.
- A single-beat packet (TLAST on its first beat) returns to IDLE after one FWD cycle.
- Fairness: with all requesters permanently valid, grants cycle 0,1,…,MAX_ACCS-1,0,…; no accelerator waits more than MAX_ACCS-1 packets.
- Simultaneous output drain and new input accept in the same cycle: the register is overwritten with the new beat, and TVALID stays 1.

Test Plan:
- Single requester: reset, acc 5 sends 3 beats 0x11/0x22/0x33 with TLAST on the third, outStream_TREADY=1 → outStream shows the same 3 beats with TID=5 in consecutive cycles, TLAST only on 0x33, pkt_count=1.
- Round-robin: accs 0, 3 and 7 all valid with 3-beat packets, rr_ptr at reset → packet order 0, 3, 7, 0. There is one idle cycle between packets and no beat interleaving.
- Backpressure: outStream_TREADY toggles 1,0,0,1,… during a 3-beat packet from acc 2 → data/TID/TLAST stable while stalled, no beat lost or duplicated, acc_TREADY[2]=0 during stalls.
- Grant lock: acc 9 is mid-packet (beat 2 of 3) when acc 1 asserts valid → acc 9 completes first, and acc 1 is granted only after acc 9's TLAST.
- Async reset mid-packet: assert rstn=0 between clock edges after beat 1 of acc 4's packet → outStream_TVALID and acc_TREADY go 0 immediately, pkt_count=0. After release, the next grant starts from index 0.
- Wrap: force pkt_count to 0xFFFFFFFF, send one single-beat packet from acc 15 → pkt_count=0, TLAST=1, TID=15.
